// File: rtl/posit_mm_pkg.sv
// Shared register map, status/control bit positions and core opcodes for the posit job engine.
package posit_mm_pkg;

    localparam logic [2:0] ADDR_OPA    = 3'd0;
    localparam logic [2:0] ADDR_OPB    = 3'd1;
    localparam logic [2:0] ADDR_CMD    = 3'd2;
    localparam logic [2:0] ADDR_RESULT = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [2:0] ADDR_CTRL   = 3'd5;

    localparam int unsigned ST_CMD_FULL     = 0;
    localparam int unsigned ST_RES_EMPTY    = 1;
    localparam int unsigned ST_BUSY         = 2;
    localparam int unsigned ST_CMD_CNT_LSB  = 8;
    localparam int unsigned ST_RES_CNT_LSB  = 16;
    localparam int unsigned ST_OVF          = 24;
    localparam int unsigned ST_UDF          = 25;

    localparam int unsigned CTRL_IRQ_EN = 0;
    localparam int unsigned CTRL_FLUSH  = 1;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} posit_op_e;

endpackage

// File: rtl/posit_mm_fifo.sv
// Synchronous FIFO with show-ahead head, occupancy count and single-cycle flush.
module posit_mm_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop) & ~flush;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/posit_mm_accel.sv
// Avalon-MM posit job engine: queues operand/opcode jobs, issues them to an external posit core
// under result-buffer credit, and buffers results for readback with an optional level interrupt.
module posit_mm_accel
    import posit_mm_pkg::*;
#(
    parameter int unsigned NBITS        = 32,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned CORE_LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    output logic [NBITS-1:0] core_num1,
    output logic [NBITS-1:0] core_num2,
    output logic [1:0]       core_op,
    input  logic [NBITS-1:0] core_result,
    output logic             irq
);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam int unsigned CMD_W = 2 + 2 * NBITS;

    logic [NBITS-1:0]        opa_q, opb_q, num1_q, num2_q;
    posit_op_e               op_q;
    logic                    irq_en_q, ovf_q, udf_q;
    logic [CORE_LATENCY:0]   valid_sr_q, valid_sr_d;
    logic [31:0]             rdata_q, rdata_d, status;

    logic                    cmd_wr, res_rd, flush, status_wr, issue, capture, credit;
    logic [CMD_W-1:0]        cmd_head;
    logic [CW-1:0]           cmd_count, res_count;
    logic                    cmd_full, cmd_empty, res_full, res_empty;
    logic [NBITS-1:0]        res_head;
    logic [5:0]              used;

    assign cmd_wr    = avs_write && (avs_address == ADDR_CMD);
    assign status_wr = avs_write && (avs_address == ADDR_STATUS);
    assign flush     = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[CTRL_FLUSH];
    assign res_rd    = avs_read && (avs_address == ADDR_RESULT);

    posit_mm_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (cmd_wr),
        .wdata ({avs_writedata[1:0], opa_q, opb_q}),
        .pop   (issue),
        .rdata (cmd_head),
        .count (cmd_count),
        .full  (cmd_full),
        .empty (cmd_empty)
    );

    posit_mm_fifo #(.WIDTH(NBITS), .DEPTH(DEPTH)) u_res_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .push  (capture),
        .wdata (core_result),
        .pop   (res_rd),
        .rdata (res_head),
        .count (res_count),
        .full  (res_full),
        .empty (res_empty)
    );

    // Every tag in flight plus every buffered result owns a result slot, so a capture never drops.
    always_comb begin
        used = 6'(res_count);
        for (int unsigned i = 0; i <= CORE_LATENCY; i++) begin
            used = used + 6'(valid_sr_q[i]);
        end
        credit = (used < 6'(DEPTH));
        issue  = ~cmd_empty & credit & ~flush;

        valid_sr_d[0] = issue;
        for (int unsigned i = 1; i <= CORE_LATENCY; i++) begin
            valid_sr_d[i] = valid_sr_q[i-1];
        end
        if (flush) valid_sr_d = '0;
    end

    assign capture = valid_sr_q[CORE_LATENCY] & ~flush;

    always_comb begin
        status = '0;
        status[ST_CMD_FULL]             = cmd_full;
        status[ST_RES_EMPTY]            = res_empty;
        status[ST_BUSY]                 = ~cmd_empty | (|valid_sr_q);
        status[ST_CMD_CNT_LSB +: 5]     = 5'(cmd_count);
        status[ST_RES_CNT_LSB +: 5]     = 5'(res_count);
        status[ST_OVF]                  = ovf_q;
        status[ST_UDF]                  = udf_q;

        rdata_d = rdata_q;
        if (avs_read) begin
            case (avs_address)
                ADDR_OPA:    rdata_d = 32'(opa_q);
                ADDR_OPB:    rdata_d = 32'(opb_q);
                ADDR_RESULT: rdata_d = res_empty ? '0 : 32'(res_head);
                ADDR_STATUS: rdata_d = status;
                ADDR_CTRL:   rdata_d = 32'(irq_en_q);
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            opa_q      <= '0;
            opb_q      <= '0;
            num1_q     <= '0;
            num2_q     <= '0;
            op_q       <= OP_ADD;
            irq_en_q   <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            valid_sr_q <= '0;
            rdata_q    <= '0;
        end else begin
            if (avs_write && avs_address == ADDR_OPA) opa_q <= avs_writedata[NBITS-1:0];
            if (avs_write && avs_address == ADDR_OPB) opb_q <= avs_writedata[NBITS-1:0];
            if (avs_write && avs_address == ADDR_CTRL) irq_en_q <= avs_writedata[CTRL_IRQ_EN];
            if (issue) begin
                op_q   <= posit_op_e'(cmd_head[CMD_W-1 -: 2]);
                num1_q <= cmd_head[2*NBITS-1 -: NBITS];
                num2_q <= cmd_head[NBITS-1:0];
            end
            ovf_q <= (ovf_q & ~(status_wr & avs_writedata[ST_OVF]))
                   | (cmd_wr & ~flush & cmd_full & ~issue);
            udf_q <= (udf_q & ~(status_wr & avs_writedata[ST_UDF])) | (res_rd & res_empty);
            valid_sr_q <= valid_sr_d;
            rdata_q    <= rdata_d;
        end
    end

    assign avs_readdata = rdata_q;
    assign core_num1    = num1_q;
    assign core_num2    = num2_q;
    assign core_op      = op_q;
    assign irq          = irq_en_q & ~res_empty;

endmodule

// File: tb/tb_posit_mm_accel.sv
// Self-checking bench: posit32 es2 reference core with configurable latency, table vectors,
// scoreboard of expected results, and hand sequences for overflow, underflow, irq and flush/reset.
module tb_posit_mm_accel;
    import posit_mm_pkg::*;

    localparam int unsigned NB  = 32;
    localparam int unsigned DEP = 8;
    localparam int unsigned LAT = 1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  avs_address = '0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = '0;
    logic        avs_read = 1'b0;
    logic [31:0] avs_readdata;
    logic [31:0] core_num1, core_num2, core_result, core_fn_out;
    logic [1:0]  core_op;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [31:0] sb [$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    posit_mm_accel #(.NBITS(NB), .DEPTH(DEP), .CORE_LATENCY(LAT)) dut (
        .clock         (clock),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .core_num1     (core_num1),
        .core_num2     (core_num2),
        .core_op       (core_op),
        .core_result   (core_result),
        .irq           (irq)
    );

    // ---------------- posit32 es=2 reference ----------------
    function automatic real pow2(input int s);
        real r = 1.0;
        if (s >= 0) for (int n = 0; n < s; n++) r = r * 2.0;
        else        for (int n = 0; n < -s; n++) r = r / 2.0;
        return r;
    endfunction

    function automatic real p2r(input logic [31:0] p);
        logic [31:0] v;
        logic        r;
        int          i, run, k, e;
        real         f, w, val;
        if (p[30:0] == 31'd0) return 0.0;
        v = p[31] ? (~p + 32'd1) : p;
        r = v[30];
        run = 0;
        i = 30;
        while (i >= 0) begin
            if (v[i] != r) break;
            run++;
            i--;
        end
        k = r ? run - 1 : -run;
        i--;
        e = 0;
        for (int n = 0; n < 2; n++) begin
            e = e * 2;
            if (i >= 0) e = e + int'(v[i]);
            i--;
        end
        f = 1.0;
        w = 0.5;
        while (i >= 0) begin
            if (v[i]) f = f + w;
            w = w / 2.0;
            i--;
        end
        val = f * pow2(4 * k + e);
        return p[31] ? -val : val;
    endfunction

    function automatic logic [31:0] r2p(input real x_in);
        real         x, f;
        int          s, k, e, pos;
        logic [31:0] v;
        logic        neg;
        x = x_in;
        v = '0;
        if (x == 0.0) return '0;
        neg = (x < 0.0);
        if (neg) x = -x;
        s = 0;
        while (x >= 2.0) begin x = x / 2.0; s++; end
        while (x < 1.0)  begin x = x * 2.0; s--; end
        k = (s >= 0) ? s / 4 : -((3 - s) / 4);
        e = s - 4 * k;
        pos = 30;
        if (k >= 0) begin
            for (int n = 0; n <= k; n++) begin
                if (pos >= 0) v[pos] = 1'b1;
                pos--;
            end
            pos--;
        end else begin
            pos = pos + k;
            if (pos >= 0) v[pos] = 1'b1;
            pos--;
        end
        for (int n = 1; n >= 0; n--) begin
            if (pos >= 0) v[pos] = (((e >> n) & 1) != 0);
            pos--;
        end
        f = x - 1.0;
        while (pos >= 0) begin
            f = f * 2.0;
            if (f >= 1.0) begin v[pos] = 1'b1; f = f - 1.0; end
            pos--;
        end
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] core_calc(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] op);
        real ra, rb;
        ra = p2r(a);
        rb = p2r(b);
        case (op)
            2'd0:    return r2p(ra + rb);
            2'd1:    return r2p(ra - rb);
            2'd2:    return r2p(ra * rb);
            default: return (rb == 0.0) ? 32'h8000_0000 : r2p(ra / rb);
        endcase
    endfunction

    always_comb core_fn_out = core_calc(core_num1, core_num2, core_op);

    generate
        if (LAT == 0) begin : g_comb
            assign core_result = core_fn_out;
        end else begin : g_pipe
            logic [31:0] pipe [LAT];
            always @(posedge clock) begin
                pipe[0] <= core_fn_out;
                for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
            end
            assign core_result = pipe[LAT-1];
        end
    endgenerate

    // ---------------- checking and bus helpers ----------------
    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clock);
        avs_write     = 1'b0;
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        avs_address = a;
        avs_read    = 1'b1;
        @(negedge clock);
        avs_read    = 1'b0;
        d           = avs_readdata;
    endtask

    task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        check32(name, d, exp);
    endtask

    task automatic rd_result_sb(input string name);
        logic [31:0] d;
        bus_rd(ADDR_RESULT, d);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected nothing (scoreboard empty)", name, d);
        end else begin
            check32(name, d, sb.pop_front());
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [1:0]  ops5 [8];
    int          t_issue, t_irq;

    initial begin
        vecs[0] = '{32'h4000_0000, 32'h4000_0000, 2'd0, 32'h4800_0000}; // 1+1=2
        vecs[1] = '{32'h4000_0000, 32'h4800_0000, 2'd0, 32'h4C00_0000}; // 1+2=3
        vecs[2] = '{32'h4800_0000, 32'h4800_0000, 2'd2, 32'h5000_0000}; // 2*2=4
        vecs[3] = '{32'h4000_0000, 32'h4000_0000, 2'd1, 32'h0000_0000}; // 1-1=0
        vecs[4] = '{32'h4000_0000, 32'h4800_0000, 2'd1, 32'hC000_0000}; // 1-2=-1
        vecs[5] = '{32'h5000_0000, 32'h5000_0000, 2'd2, 32'h6000_0000}; // 4*4=16
        vecs[6] = '{32'h4000_0000, 32'h4800_0000, 2'd3, 32'h3800_0000}; // 1/2=0.5
        vecs[7] = '{32'h4C00_0000, 32'h4C00_0000, 2'd2, 32'h5900_0000}; // 3*3=9
        ops5    = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1};

        // Reset state
        repeat (2) @(negedge clock);
        check32("reset_readdata", avs_readdata, 32'h0);
        check32("reset_core_num1", core_num1, 32'h0);
        check32("reset_core_op", 32'(core_op), 32'h0);
        check32("reset_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        @(negedge clock);
        rd_check("reset_status", ADDR_STATUS, 32'h0000_0002);
        rd_check("reset_ctrl", ADDR_CTRL, 32'h0);

        // 1 + 4: single job, capture latency and irq
        bus_wr(ADDR_CTRL, 32'h1);
        bus_wr(ADDR_OPA, 32'h4000_0000);
        bus_wr(ADDR_OPB, 32'h4000_0000);
        rd_check("opa_readback", ADDR_OPA, 32'h4000_0000);
        bus_wr(ADDR_CMD, 32'(OP_ADD));
        sb.push_back(32'h4800_0000);
        t_issue = -1;
        t_irq   = -1;
        for (int k = 0; k < 20; k++) begin
            if (t_issue < 0 && core_num1 == 32'h4000_0000 && core_num2 == 32'h4000_0000) t_issue = cyc;
            if (t_irq < 0 && irq) t_irq = cyc;
            @(negedge clock);
        end
        check32("t1_issue_seen", 32'(t_issue >= 0), 32'h1);
        check32("t1_capture_latency", 32'(t_irq - t_issue), 32'(1 + LAT));
        check32("t4_irq_high", 32'(irq), 32'h1);
        rd_result_sb("t1_result");
        check32("t4_irq_low_after_pop", 32'(irq), 32'h0);

        // Table vectors
        for (int i = 0; i < 8; i++) begin
            bus_wr(ADDR_OPA, vecs[i].a);
            bus_wr(ADDR_OPB, vecs[i].b);
            bus_wr(ADDR_CMD, 32'(vecs[i].op));
            sb.push_back(vecs[i].exp);
        end
        repeat (10) @(negedge clock);
        for (int i = 0; i < 8; i++) rd_result_sb($sformatf("vec%0d", i));

        // 2: fill result FIFO, then overflow the command FIFO
        bus_wr(ADDR_OPB, r2p(1.0));
        for (int j = 0; j < 8; j++) begin
            bus_wr(ADDR_OPA, r2p(real'(j + 1)));
            bus_wr(ADDR_CMD, 32'(OP_ADD));
            sb.push_back(core_calc(r2p(real'(j + 1)), r2p(1.0), 2'd0));
        end
        repeat (10) @(negedge clock);
        bus_wr(ADDR_OPA, r2p(3.0));
        bus_wr(ADDR_OPB, r2p(2.0));
        for (int j = 0; j < 9; j++) begin
            bus_wr(ADDR_CMD, (j % 2 == 0) ? 32'(OP_ADD) : 32'(OP_MUL));
            if (j < 8) sb.push_back(core_calc(r2p(3.0), r2p(2.0), (j % 2 == 0) ? 2'd0 : 2'd2));
        end
        rd_check("t2_status_full", ADDR_STATUS, 32'h0108_0805);
        bus_wr(ADDR_STATUS, 32'h0100_0000);
        for (int j = 0; j < 8; j++) rd_result_sb($sformatf("t2_first%0d", j));
        repeat (12) @(negedge clock);
        for (int j = 0; j < 8; j++) rd_result_sb($sformatf("t2_second%0d", j));
        rd_check("t2_status_drained", ADDR_STATUS, 32'h0000_0002);

        // 3: underflow sticky and its clear
        rd_check("t3_empty_read", ADDR_RESULT, 32'h0);
        rd_check("t3_udf_set", ADDR_STATUS, 32'h0200_0002);
        bus_wr(ADDR_STATUS, 32'h0200_0000);
        rd_check("t3_udf_clr", ADDR_STATUS, 32'h0000_0002);

        // 5: back-to-back commands, one issue per cycle in order
        bus_wr(ADDR_OPA, r2p(3.0));
        bus_wr(ADDR_OPB, r2p(2.0));
        for (int k = 0; k < 8; k++) begin
            bus_wr(ADDR_CMD, 32'(ops5[k]));
            sb.push_back(core_calc(r2p(3.0), r2p(2.0), ops5[k]));
            if (k > 0) check32($sformatf("t5_issue_op%0d", k - 1), 32'(core_op), 32'(ops5[k-1]));
        end
        @(negedge clock);
        check32("t5_issue_op7", 32'(core_op), 32'(ops5[7]));
        repeat (6) @(negedge clock);
        rd_check("t5_status", ADDR_STATUS, 32'h0008_0000);
        for (int k = 0; k < 8; k++) rd_result_sb($sformatf("t5_result%0d", k));

        // 6a: flush with jobs in flight; udf survives
        rd_check("t6_empty_read", ADDR_RESULT, 32'h0);
        for (int k = 0; k < 3; k++) bus_wr(ADDR_CMD, 32'(OP_MUL));
        bus_wr(ADDR_CTRL, 32'h3);
        repeat (10) @(negedge clock);
        check32("t6_flush_irq", 32'(irq), 32'h0);
        rd_check("t6_flush_status", ADDR_STATUS, 32'h0200_0002);
        rd_check("t6_flush_ctrl", ADDR_CTRL, 32'h1);

        // 6b: reset with jobs in flight clears everything
        for (int k = 0; k < 3; k++) bus_wr(ADDR_CMD, 32'(OP_ADD));
        reset = 1'b1;
        @(negedge clock);
        check32("t6_rst_irq", 32'(irq), 32'h0);
        check32("t6_rst_readdata", avs_readdata, 32'h0);
        check32("t6_rst_core_num1", core_num1, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        rd_check("t6_rst_status", ADDR_STATUS, 32'h0000_0002);
        rd_check("t6_rst_ctrl", ADDR_CTRL, 32'h0);
        rd_check("t6_rst_opa", ADDR_OPA, 32'h0);
        rd_check("reserved_read", 3'd6, 32'h0);
        check32("sb_drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
